// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered read.
// The array has no reset so it maps onto block or distributed RAM.
module fifo_sdp_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem_r [0:DEPTH-1];

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // registered read port, holds its word while re is low
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with count-based flags, almost thresholds, over/underflow pulses
// and either a standard or a first-word-fall-through read interface.
module sync_fifo_fwft
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 256,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = DEPTH - 4,
  parameter int AEMPTY_TH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         din,
  output logic                      full,
  output logic                      almost_full,
  output logic                      overflow,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         dout,
  output logic                      valid,
  output logic                      empty,
  output logic                      almost_empty,
  output logic                      underflow,
  output logic [cnt_w(DEPTH)-1:0]   data_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              full_r, afull_r, ovf_r, empty_r, aempty_r, uflow_r;
  logic              valid_r, pend_r;
  logic [DATA_W-1:0] dout_r;
  logic [DATA_W-1:0] ram_q_s;

  logic              wr_acc_s, pop_s, issue_s, load_s;
  logic              pend_next_s, valid_next_s, empty_next_s;
  logic [CW-1:0]     count_next_s;

  fifo_sdp_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (wr_acc_s),
    .waddr (wr_ptr_r),
    .wdata (din),
    .re    (issue_s),
    .raddr (rd_ptr_r),
    .rdata (ram_q_s)
  );

  // accepted write and resulting occupancy
  always_comb begin
    wr_acc_s     = wr_en && !full_r;
    count_next_s = count_r + CW'(wr_acc_s) - CW'(pop_s);
  end

  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft
      logic [CW-1:0] mem_words_s;

      // prefetch: keep the RAM read stage and the output stage topped up from memory
      always_comb begin
        mem_words_s  = count_r - CW'(valid_r) - CW'(pend_r);
        pop_s        = rd_en && !empty_r;
        load_s       = pend_r && (!valid_r || pop_s);
        issue_s      = (mem_words_s != {CW{1'b0}}) && (!pend_r || load_s);
        pend_next_s  = issue_s || (pend_r && !load_s);
        if (load_s) begin
          valid_next_s = 1'b1;
        end else if (pop_s) begin
          valid_next_s = 1'b0;
        end else begin
          valid_next_s = valid_r;
        end
        empty_next_s = !valid_next_s;
      end
    end else begin : g_std
      // standard read: each accepted read walks through the RAM and output registers
      always_comb begin
        pop_s        = rd_en && !empty_r;
        issue_s      = pop_s;
        load_s       = pend_r;
        pend_next_s  = issue_s;
        valid_next_s = pend_r;
        empty_next_s = (count_next_s == {CW{1'b0}});
      end
    end
  endgenerate

  // pointers, count, registered flags and output stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
      afull_r  <= 1'b0;
      ovf_r    <= 1'b0;
      empty_r  <= 1'b1;
      aempty_r <= 1'b1;
      uflow_r  <= 1'b0;
      valid_r  <= 1'b0;
      pend_r   <= 1'b0;
      dout_r   <= {DATA_W{1'b0}};
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (issue_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r  <= count_next_s;
      full_r   <= (count_next_s == DEPTH_C);
      afull_r  <= (count_next_s >= AFULL_C);
      aempty_r <= (count_next_s <= AEMPTY_C);
      empty_r  <= empty_next_s;
      ovf_r    <= wr_en && full_r;
      uflow_r  <= rd_en && empty_r;
      pend_r   <= pend_next_s;
      valid_r  <= valid_next_s;
      if (load_s) begin
        dout_r <= ram_q_s;
      end
    end
  end

  assign full         = full_r;
  assign almost_full  = afull_r;
  assign overflow     = ovf_r;
  assign dout         = dout_r;
  assign valid        = valid_r;
  assign empty        = empty_r;
  assign almost_empty = aempty_r;
  assign underflow    = uflow_r;
  assign data_count   = count_r;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed bench: both read modes driven with the same stimulus, one DUT checked per pass.
module tb_sync_fifo_fwft;

  logic        clk = 1'b0;
  logic        rst_n, wr_en, rd_en;
  logic [15:0] din;
  logic        mode;

  logic        std_full, std_afull, std_ovf, std_valid, std_empty, std_aempty, std_uflow;
  logic        ff_full, ff_afull, ff_ovf, ff_valid, ff_empty, ff_aempty, ff_uflow;
  logic [15:0] std_dout, ff_dout;
  logic [4:0]  std_cnt, ff_cnt;

  logic        s_full, s_afull, s_ovf, s_valid, s_empty, s_aempty, s_uflow;
  logic [15:0] s_dout;
  logic [4:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_fwft #(.DATA_W(16), .DEPTH(16), .FWFT(0), .AFULL_TH(12), .AEMPTY_TH(2)) u_std (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .full(std_full),
    .almost_full(std_afull), .overflow(std_ovf), .rd_en(rd_en), .dout(std_dout),
    .valid(std_valid), .empty(std_empty), .almost_empty(std_aempty),
    .underflow(std_uflow), .data_count(std_cnt)
  );

  sync_fifo_fwft #(.DATA_W(16), .DEPTH(16), .FWFT(1), .AFULL_TH(12), .AEMPTY_TH(2)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .full(ff_full),
    .almost_full(ff_afull), .overflow(ff_ovf), .rd_en(rd_en), .dout(ff_dout),
    .valid(ff_valid), .empty(ff_empty), .almost_empty(ff_aempty),
    .underflow(ff_uflow), .data_count(ff_cnt)
  );

  always_comb begin
    if (mode) begin
      s_full = ff_full;   s_afull = ff_afull;   s_ovf = ff_ovf;     s_valid = ff_valid;
      s_empty = ff_empty; s_aempty = ff_aempty; s_uflow = ff_uflow; s_dout = ff_dout;
      s_cnt = ff_cnt;
    end else begin
      s_full = std_full;   s_afull = std_afull;   s_ovf = std_ovf;     s_valid = std_valid;
      s_empty = std_empty; s_aempty = std_aempty; s_uflow = std_uflow; s_dout = std_dout;
      s_cnt = std_cnt;
    end
  end

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] d;
    logic [4:0]  cnt;
    logic        full;
    logic        afull;
    logic        ovf;
    logic        empty_std;
    logic        empty_fwft;
    logic        aempty;
  } vec_t;

  vec_t vecs [0:17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (fwft=%0d t=%0t): got %0h expected %0h", name, mode, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_full"}, 32'(s_full), 32'd0);
    chk({tag, "_afull"}, 32'(s_afull), 32'd0);
    chk({tag, "_ovf"}, 32'(s_ovf), 32'd0);
    chk({tag, "_empty"}, 32'(s_empty), 32'd1);
    chk({tag, "_aempty"}, 32'(s_aempty), 32'd1);
    chk({tag, "_uflow"}, 32'(s_uflow), 32'd0);
    chk({tag, "_valid"}, 32'(s_valid), 32'd0);
    chk({tag, "_dout"}, 32'(s_dout), 32'd0);
    chk({tag, "_count"}, 32'(s_cnt), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = 16'h0000;
    step();
    check_reset("reset");
    rst_n = 1'b1;
  endtask

  task automatic fill(input int n);
    for (int i = 1; i <= n; i++) begin
      wr_en = 1'b1; din = 16'(i);
      step();
    end
    wr_en = 1'b0;
  endtask

  // single word into an empty FIFO, read back in the mode-appropriate way
  task automatic write_then_read(input logic [15:0] v, input string tag);
    wr_en = 1'b1; din = v; rd_en = 1'b0;
    step();
    chk({tag, "_count1"}, 32'(s_cnt), 32'd1);
    wr_en = 1'b0; din = 16'hxxxx;
    rd_en = !mode;
    step();
    chk({tag, "_valid_early"}, 32'(s_valid), 32'd0);
    rd_en = 1'b0;
    step();
    chk({tag, "_valid"}, 32'(s_valid), 32'd1);
    chk({tag, "_dout"}, 32'(s_dout), 32'(v));
    chk({tag, "_empty"}, 32'(s_empty), 32'(!mode));
    step();
    chk({tag, "_valid_after"}, 32'(s_valid), 32'(mode));
    chk({tag, "_dout_hold"}, 32'(s_dout), 32'(v));
    chk({tag, "_count_after"}, 32'(s_cnt), 32'(mode));
  endtask

  task automatic run_pass();
    logic [15:0] exp_w;
    logic [15:0] nxt;

    // fill to full and overflow via the vector table
    do_reset();
    for (int i = 0; i < 18; i++) begin
      wr_en = vecs[i].wr; rd_en = vecs[i].rd; din = vecs[i].d;
      step();
      chk($sformatf("fill%0d_count", i), 32'(s_cnt), 32'(vecs[i].cnt));
      chk($sformatf("fill%0d_full", i), 32'(s_full), 32'(vecs[i].full));
      chk($sformatf("fill%0d_afull", i), 32'(s_afull), 32'(vecs[i].afull));
      chk($sformatf("fill%0d_ovf", i), 32'(s_ovf), 32'(vecs[i].ovf));
      chk($sformatf("fill%0d_empty", i), 32'(s_empty),
          32'(mode ? vecs[i].empty_fwft : vecs[i].empty_std));
      chk($sformatf("fill%0d_aempty", i), 32'(s_aempty), 32'(vecs[i].aempty));
    end

    // drain with rd_en held, one extra read for underflow
    exp_w = 16'd1;
    wr_en = 1'b0; rd_en = 1'b1;
    if (mode && s_valid) begin chk("drain_word", 32'(s_dout), 32'(exp_w)); exp_w++; end
    for (int k = 1; k <= 18; k++) begin
      step();
      chk($sformatf("drain%0d_uflow", k), 32'(s_uflow), 32'(k == 17));
      if (k == 16) chk("drain_empty_last", 32'(s_empty), 32'd1);
      if (!mode && s_valid) begin chk("drain_word", 32'(s_dout), 32'(exp_w)); exp_w++; end
      if (k == 17) rd_en = 1'b0;
      if (mode && s_valid && rd_en) begin chk("drain_word", 32'(s_dout), 32'(exp_w)); exp_w++; end
    end
    chk("drain_total", 32'(exp_w), 32'd17);
    chk("drain_dout_hold", 32'(s_dout), 32'd16);
    chk("drain_count", 32'(s_cnt), 32'd0);
    chk("drain_valid", 32'(s_valid), 32'd0);

    // single word latency
    do_reset();
    write_then_read(16'hA5A5, "single");

    // steady streaming at count 5 across many pointer wraps
    do_reset();
    fill(5);
    repeat (3) step();
    exp_w = 16'd1; nxt = 16'd6;
    wr_en = 1'b1; rd_en = 1'b1;
    for (int c = 0; c < 100; c++) begin
      din = nxt; nxt++;
      if (mode && s_valid) begin chk("stream_word", 32'(s_dout), 32'(exp_w)); exp_w++; end
      step();
      chk("stream_count", 32'(s_cnt), 32'd5);
      if (!mode && s_valid) begin chk("stream_word", 32'(s_dout), 32'(exp_w)); exp_w++; end
    end
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (2) begin
      step();
      if (!mode && s_valid) begin chk("stream_word", 32'(s_dout), 32'(exp_w)); exp_w++; end
    end
    chk("stream_total", 32'(exp_w), 32'd101);

    // write at full with a simultaneous read
    do_reset();
    fill(16);
    repeat (2) step();
    chk("wfull_full", 32'(s_full), 32'd1);
    wr_en = 1'b1; rd_en = 1'b1; din = 16'h0077;
    step();
    chk("wfull_ovf", 32'(s_ovf), 32'd1);
    chk("wfull_count", 32'(s_cnt), 32'd15);
    chk("wfull_full_after", 32'(s_full), 32'd0);
    wr_en = 1'b0; rd_en = 1'b0;
    step();
    chk("wfull_ovf_pulse", 32'(s_ovf), 32'd0);
    chk("wfull_count_hold", 32'(s_cnt), 32'd15);

    // reset in the middle of traffic
    do_reset();
    fill(9);
    wr_en = 1'b1; rd_en = 1'b1;
    din = 16'd10; step();
    din = 16'd11; step();
    chk("midrst_count", 32'(s_cnt), 32'd9);
    rst_n = 1'b0; din = 16'd12;
    step();
    check_reset("midrst");
    rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    write_then_read(16'h0042, "postrst");
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = 16'h0000; mode = 1'b0;
    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{1'b1, 1'b0, 16'(i + 1), 5'(i + 1), (i == 15), (i + 1 >= 12), 1'b0,
                  1'b0, (i < 2), (i + 1 <= 2)};
    end
    vecs[16] = '{1'b1, 1'b0, 16'h0011, 5'd16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 16'h0000, 5'd16, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int m = 0; m < 2; m++) begin
      mode = m[0];
      run_pass();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
